// File: rtl/adder_bist_checker.sv
// Exhaustive self-test engine for a W-bit adder: sweeps every {a,b,cin}, compares
// against a golden sum, counts mismatches and latches the first failing vector.
module adder_bist_checker #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [W-1:0]   dut_a,
    output logic [W-1:0]   dut_b,
    output logic           dut_cin,
    input  logic [W-1:0]   dut_s,
    input  logic           dut_cout,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W+1:0] err_count,
    output logic           fail_valid,
    output logic [W-1:0]   fail_a,
    output logic [W-1:0]   fail_b,
    output logic           fail_cin
);
    localparam int VW = 2 * W + 1;
    localparam int N  = 1 << VW;
    localparam logic [VW-1:0] V_LAST = VW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [VW-1:0]   v_q, v_d, v_nxt;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d;
    logic [2*W+1:0]  err_q, err_d;
    logic            fv_q, fv_d;
    logic [W-1:0]    fa_q, fa_d, fb_q, fb_d;
    logic            fcin_q, fcin_d;
    logic [W:0]      golden;
    logic            mismatch;

    assign golden   = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
    assign mismatch = ({dut_cout, dut_s} != golden);
    assign v_nxt    = v_q + VW'(1);

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fcin_d  = fcin_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    v_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                    cin_d   = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    fcin_d  = 1'b0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fa_d   = a_q;
                        fb_d   = b_q;
                        fcin_d = cin_q;
                    end
                end
                // Last vector keeps the drive registers so the adder inputs stay stable in DONE.
                if (v_q == V_LAST) begin
                    state_d = DONE;
                end else begin
                    v_d   = v_nxt;
                    a_d   = v_nxt[2*W:W+1];
                    b_d   = v_nxt[W:1];
                    cin_d = v_nxt[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fcin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fcin_q  <= fcin_d;
        end
    end

    assign dut_a      = a_q;
    assign dut_b      = b_q;
    assign dut_cin    = cin_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_cin   = fcin_q;
endmodule

// File: tb/tb_adder_bist_checker.sv
// Scoreboard bench: a behavioural adder (with selectable faults) feeds the engine; expected
// sweeps are pushed at start, monitors pop and compare as vectors and done appear.
module tb_adder_bist_checker;
    typedef struct {
        int err;
        int fv;
        int fa;
        int fb;
        int fcin;
        int ps;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start2 = 1'b0;
    int   fault = 0;
    int   cyc = 0, start_cyc = 0, start_cyc2 = 0;
    int   n_chk = 0, n_fail = 0;
    int   adder4, adder2;
    bit   done_d = 1'b0, done2_d = 1'b0;
    res_t res_q[$], res_q2[$];
    int   vec_q[$];

    logic [3:0] dut_a, dut_b, dut_s, fail_a, fail_b;
    logic       dut_cin, dut_cout, busy, done, pass, fail_valid, fail_cin;
    logic [9:0] err_count;
    logic [1:0] dut_a2, dut_b2, dut_s2, fail_a2, fail_b2;
    logic       dut_cin2, dut_cout2, busy2, done2, pass2, fail_valid2, fail_cin2;
    logic [5:0] err_count2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder: fault 1 = carry-out stuck at 0, fault 2 = sum bit 0 inverted.
    function automatic int adder_out(input int w, input int flt, input int a, input int b, input int c);
        int s, cout, sum;
        s    = a + b + c;
        cout = s >> w;
        sum  = s & ((1 << w) - 1);
        if (flt == 1) cout = 0;
        if (flt == 2) sum = sum ^ 1;
        return (cout << w) | sum;
    endfunction

    assign adder4 = adder_out(4, fault, int'(dut_a), int'(dut_b), int'(dut_cin));
    assign dut_s = adder4[3:0];
    assign dut_cout = adder4[4];
    assign adder2 = adder_out(2, 0, int'(dut_a2), int'(dut_b2), int'(dut_cin2));
    assign dut_s2 = adder2[1:0];
    assign dut_cout2 = adder2[2];

    adder_bist_checker #(.W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin), .dut_s(dut_s), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_valid(fail_valid),
        .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin)
    );

    adder_bist_checker #(.W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_a(dut_a2), .dut_b(dut_b2), .dut_cin(dut_cin2), .dut_s(dut_s2), .dut_cout(dut_cout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .fail_valid(fail_valid2),
        .fail_a(fail_a2), .fail_b(fail_b2), .fail_cin(fail_cin2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk every operand triple (a slowest, cin fastest) and judge against a+b+cin.
    function automatic res_t predict(input int w, input int flt);
        res_t r;
        r = '{0, 0, 0, 0, 0, 0};
        for (int a = 0; a < (1 << w); a++)
            for (int b = 0; b < (1 << w); b++)
                for (int c = 0; c < 2; c++)
                    if (adder_out(w, flt, a, b, c) != a + b + c) begin
                        if (r.fv == 0) begin
                            r.fv = 1; r.fa = a; r.fb = b; r.fcin = c;
                        end
                        r.err++;
                    end
        r.ps = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic expect_sweep(input int flt);
        res_q.push_back(predict(4, flt));
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    vec_q.push_back((a << 5) | (b << 1) | c);
    endtask

    task automatic pulse(input bit rec);
        start = 1'b1;
        @(posedge clk);
        if (rec) start_cyc = cyc;
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", int'(seen), 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, int'(dut_a), 0);
        chk({tag, "_b"}, int'(dut_b), 0);
        chk({tag, "_cin"}, int'(dut_cin), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_fv"}, int'(fail_valid), 0);
        chk({tag, "_fa"}, int'(fail_a), 0);
        chk({tag, "_fb"}, int'(fail_b), 0);
        chk({tag, "_fcin"}, int'(fail_cin), 0);
    endtask

    // W=4 monitor: per-busy-cycle vector order, exclusivity, and result at done rise.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_excl", int'(busy && done), 0);
            if (busy) begin
                if (vec_q.size() == 0) chk("vec_unexpected", 1, 0);
                else chk("vec_order", int'({dut_a, dut_b, dut_cin}), vec_q.pop_front());
            end
            if (done && !done_d) begin
                if (res_q.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    res_t e;
                    e = res_q.pop_front();
                    chk("latency", cyc - start_cyc, 513);
                    chk("err_count", int'(err_count), e.err);
                    chk("pass", int'(pass), e.ps);
                    chk("fail_valid", int'(fail_valid), e.fv);
                    chk("fail_a", int'(fail_a), e.fa);
                    chk("fail_b", int'(fail_b), e.fb);
                    chk("fail_cin", int'(fail_cin), e.fcin);
                    chk("hold_vec", int'({dut_a, dut_b, dut_cin}), 511);
                end
            end
        end
        done_d = done;
    end

    always @(negedge clk) begin
        if (rst_n && done2 && !done2_d) begin
            if (res_q2.size() == 0) chk("res2_unexpected", 1, 0);
            else begin
                res_t e;
                e = res_q2.pop_front();
                chk("w2_latency", cyc - start_cyc2, 33);
                chk("w2_err_count", int'(err_count2), e.err);
                chk("w2_pass", int'(pass2), e.ps);
                chk("w2_fail_valid", int'(fail_valid2), e.fv);
                chk("w2_busy", int'(busy2), 0);
            end
        end
        done2_d = done2;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        fault = 0; expect_sweep(0); pulse(1'b1); wait_done();
        fault = 1; expect_sweep(1); pulse(1'b1); wait_done();
        fault = 2; expect_sweep(2); pulse(1'b1); wait_done();

        // Start during RUN must be ignored; then a start from DONE repeats identically.
        fault = 0; expect_sweep(0); pulse(1'b1);
        repeat (198) @(posedge clk);
        #1 pulse(1'b0);
        wait_done();
        expect_sweep(0); pulse(1'b1); wait_done();

        // Random-fault sweep interrupted by reset, then a clean sweep from vector 0.
        fault = int'($urandom_range(0, 2));
        expect_sweep(fault); pulse(1'b1);
        repeat (99) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("midrun_rst");
        vec_q.delete(); res_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        fault = int'($urandom_range(0, 2));
        expect_sweep(fault); pulse(1'b1); wait_done();

        chk("w2_err_width", $bits(err_count2), 6);
        res_q2.push_back(predict(2, 0));
        start2 = 1'b1;
        @(posedge clk);
        start_cyc2 = cyc;
        #1 start2 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                seen = done2;
            end
            chk("w2_done_seen", int'(seen), 1);
        end
        repeat (2) @(negedge clk);

        chk("queues_drained", vec_q.size() + res_q.size() + res_q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
